histo_gen: RTL

- Parametrised successor to the fixed 256-bin grey histogram.
- Bins the incoming grey stream per frame using a read-modify-write pipeline with hazard forwarding, so every valid pixel is counted exactly once.
- At frame end it scans the bins to build the cumulative histogram and finds the first bin whose cumulative count exceeds a runtime threshold.
- Results go to a double-buffered display bank that the VGA overlay reads, then the accumulator is cleared for the next frame.

---
 rtl/histo_gen.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/histo_gen.sv
// Per-frame grey-level histogram: a forwarding RMW accumulator, a cumulative scan with threshold
// search into a double-buffered display bank, then an accumulator clear.
module histo_gen #(
  parameter int PIX_W    = 12,
  parameter int BIN_BITS = 8,
  parameter int CNT_W    = 20
) (
  input  logic                iPclk,
  input  logic                iRst,
  input  logic                iFval,
  input  logic                iDval,
  input  logic [PIX_W-1:0]    iGrey,
  input  logic [CNT_W-1:0]    iThresh,
  input  logic [BIN_BITS-1:0] iRd_Bin,
  output logic [CNT_W-1:0]    oHist,
  output logic [CNT_W-1:0]    oCum,
  output logic [BIN_BITS-1:0] oThresh_Bin,
  output logic                oThresh_Valid,
  output logic                oFrame_Done,
  output logic                oDrop,
  output logic                oSat,
  output logic                oBusy
);

  localparam int              NB         = 1 << BIN_BITS;
  localparam int              SW         = BIN_BITS + 2;
  localparam logic [SW-1:0]   SCAN_DRAIN = SW'(2);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCAN, S_CLEAR} state_e;
  state_e state_q, state_d;

  logic                fval_q, fval_rise, fval_fall, pix_vld;
  logic [BIN_BITS-1:0] pix_bin, acc_ra, acc_wa, clr_cnt_q, scan_addr;
  logic                acc_we;
  logic [CNT_W-1:0]    acc_wd, acc_rd_q, acc_mem [NB];
  logic                s1_vld_q, s2_vld_q, s3_vld_q;
  logic [BIN_BITS-1:0] s1_bin_q, s2_bin_q, s3_bin_q;
  logic [CNT_W-1:0]    s2_cnt_q, s3_cnt_q, fwd_cnt, inc_cnt;
  logic                inc_sat, sat_q;
  logic [SW-1:0]       scan_cnt_q, scan_off;
  logic                scan_rd, scan_done, sc1_vld_q;
  logic [BIN_BITS-1:0] sc1_bin_q, fbin_q;
  logic [CNT_W-1:0]    thr_q, cum_q, cum_d;
  logic [CNT_W:0]      cum_sum;
  logic                cum_carry, cum_hit, found_q;
  logic                front_q, disp_vld_q, dr_vld_q;
  logic [CNT_W-1:0]    dr_hist_q, dr_cum_q;
  logic [CNT_W-1:0]    disp_hist_mem [2*NB];
  logic [CNT_W-1:0]    disp_cum_mem  [2*NB];

  assign pix_bin   = iGrey[PIX_W-1 -: BIN_BITS];
  assign fval_rise = iFval & ~fval_q;
  assign fval_fall = ~iFval & fval_q;
  assign pix_vld   = iFval & iDval & ((state_q == S_ACCUM) | ((state_q == S_IDLE) & fval_rise));
  assign oBusy     = (state_q == S_SCAN) | (state_q == S_CLEAR);

  generate
    if (PIX_W > BIN_BITS) begin : g_grey_lsb
      logic unused_grey_lsb;
      assign unused_grey_lsb = ^iGrey[PIX_W-BIN_BITS-1:0];
    end
  endgenerate

  // Newest in-flight write to the same bin wins: stage 2 is not yet written, stage 3 was written
  // on the same edge the RAM was read, so the RAM word is stale in both cases.
  always_comb begin
    if (s2_vld_q && (s2_bin_q == s1_bin_q))      fwd_cnt = s2_cnt_q;
    else if (s3_vld_q && (s3_bin_q == s1_bin_q)) fwd_cnt = s3_cnt_q;
    else                                         fwd_cnt = acc_rd_q;
  end
  assign inc_sat = (fwd_cnt == CNT_MAX);
  assign inc_cnt = inc_sat ? CNT_MAX : fwd_cnt + CNT_W'(1);

  // The scan waits SCAN_DRAIN cycles so the last pixels of the frame land before bin 0 is read.
  assign scan_off  = scan_cnt_q - SCAN_DRAIN;
  assign scan_rd   = (state_q == S_SCAN) && (scan_cnt_q >= SCAN_DRAIN) && (scan_off[SW-1 -: 2] == 2'b00);
  assign scan_addr = scan_off[BIN_BITS-1:0];
  assign scan_done = sc1_vld_q && (sc1_bin_q == '1);

  assign cum_sum   = {1'b0, cum_q} + {1'b0, acc_rd_q};
  assign cum_carry = cum_sum[CNT_W];
  assign cum_d     = cum_carry ? CNT_MAX : cum_sum[CNT_W-1:0];
  assign cum_hit   = cum_d > thr_q;

  assign acc_ra = (state_q == S_SCAN) ? scan_addr : pix_bin;
  assign acc_we = s2_vld_q | (state_q == S_CLEAR);
  assign acc_wa = s2_vld_q ? s2_bin_q : clr_cnt_q;
  assign acc_wd = s2_vld_q ? s2_cnt_q : '0;

  always_ff @(posedge iPclk) begin
    if (iRst) state_q <= S_CLEAR;
    else      state_q <= state_d;
  end

  // NOTE: next-state defaults to the current state first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fval_rise)         state_d = S_ACCUM;
      S_ACCUM: if (fval_fall)         state_d = S_SCAN;
      S_SCAN:  if (scan_done)         state_d = S_CLEAR;
      S_CLEAR: if (clr_cnt_q == '1)   state_d = S_IDLE;
      default:                        state_d = S_CLEAR;
    endcase
  end

  // NOTE: RAM arrays carry no reset; CLEAR zeroes the accumulator and disp_vld_q masks the display.
  always_ff @(posedge iPclk) begin
    if (acc_we) acc_mem[acc_wa] <= acc_wd;
    acc_rd_q <= acc_mem[acc_ra];
    if (sc1_vld_q) begin
      disp_hist_mem[{~front_q, sc1_bin_q}] <= acc_rd_q;
      disp_cum_mem[{~front_q, sc1_bin_q}]  <= cum_d;
    end
    dr_hist_q <= disp_hist_mem[{front_q, iRd_Bin}];
    dr_cum_q  <= disp_cum_mem[{front_q, iRd_Bin}];
  end

  always_ff @(posedge iPclk) begin
    if (iRst) begin
      fval_q        <= 1'b0;
      s1_vld_q      <= 1'b0;
      s1_bin_q      <= '0;
      s2_vld_q      <= 1'b0;
      s2_bin_q      <= '0;
      s2_cnt_q      <= '0;
      s3_vld_q      <= 1'b0;
      s3_bin_q      <= '0;
      s3_cnt_q      <= '0;
      sat_q         <= 1'b0;
      clr_cnt_q     <= '0;
      scan_cnt_q    <= '0;
      sc1_vld_q     <= 1'b0;
      sc1_bin_q     <= '0;
      thr_q         <= '0;
      cum_q         <= '0;
      found_q       <= 1'b0;
      fbin_q        <= '0;
      front_q       <= 1'b0;
      disp_vld_q    <= 1'b0;
      dr_vld_q      <= 1'b0;
      oHist         <= '0;
      oCum          <= '0;
      oThresh_Bin   <= '0;
      oThresh_Valid <= 1'b0;
      oFrame_Done   <= 1'b0;
      oDrop         <= 1'b0;
      oSat          <= 1'b0;
    end else begin
      fval_q      <= iFval;
      s1_vld_q    <= pix_vld;
      s1_bin_q    <= pix_bin;
      s2_vld_q    <= s1_vld_q;
      s2_bin_q    <= s1_bin_q;
      s2_cnt_q    <= inc_cnt;
      s3_vld_q    <= s2_vld_q;
      s3_bin_q    <= s2_bin_q;
      s3_cnt_q    <= s2_cnt_q;
      sc1_vld_q   <= scan_rd;
      sc1_bin_q   <= scan_addr;
      dr_vld_q    <= disp_vld_q;
      oHist       <= dr_vld_q ? dr_hist_q : '0;
      oCum        <= dr_vld_q ? dr_cum_q : '0;
      oFrame_Done <= 1'b0;
      oDrop       <= fval_rise & ((state_q == S_SCAN) | (state_q == S_CLEAR));
      if (s1_vld_q && inc_sat) sat_q <= 1'b1;
      case (state_q)
        S_ACCUM: if (fval_fall) begin
          thr_q      <= iThresh;
          cum_q      <= '0;
          found_q    <= 1'b0;
          scan_cnt_q <= '0;
        end
        S_SCAN: begin
          scan_cnt_q <= scan_cnt_q + SW'(1);
          if (sc1_vld_q) begin
            cum_q <= cum_d;
            if (cum_carry) sat_q <= 1'b1;
            if (cum_hit && !found_q) begin
              found_q <= 1'b1;
              fbin_q  <= sc1_bin_q;
            end
          end
          if (scan_done) begin
            front_q       <= ~front_q;
            disp_vld_q    <= 1'b1;
            oFrame_Done   <= 1'b1;
            oThresh_Valid <= found_q | cum_hit;
            oThresh_Bin   <= found_q ? fbin_q : (cum_hit ? sc1_bin_q : '1);
            oSat          <= sat_q | cum_carry;
          end
        end
        S_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + BIN_BITS'(1);
          if (clr_cnt_q == '1) sat_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
